// File: rtl/dcache_memresp_pkg.sv
// Shared constants and FSM encoding for the dcache memory-port responder.
// The optional DCACHE_MEMRESP_GAP_EN macro is consumed by dcache_memresp.sv.
package dcache_memresp_pkg;

   localparam int DC_ADDRBITS   = 32;
   localparam int DC_DATABITS   = 32;
   localparam int DC_CACHEWORDS = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RDLAT   = 2'b01,
      RDBURST = 2'b10
   } state_t;

endpackage

// File: rtl/dcache_memresp_dpram.sv
// Synchronous 1R1W word RAM; read-first when raddr and waddr collide.
// Word-wide counterpart of the dcache byte-lane RAM.
module dpram_word
   import dcache_memresp_pkg::*;
#(
   parameter int DATABITS  = DC_DATABITS,
   parameter int DEPTHBITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [DEPTHBITS-1:0] waddr,
   input  logic [DEPTHBITS-1:0] raddr,
   input  logic [DATABITS-1:0]  datain,
   output logic [DATABITS-1:0]  dataout
);

   logic [DATABITS-1:0] r_mem [2**DEPTHBITS];
   logic [DATABITS-1:0] r_dout;

   always_ff @(posedge clk) begin
      r_dout <= r_mem[raddr];
      if (we) begin
         r_mem[waddr] <= datain;
      end
   end

   assign dataout = r_dout;

endmodule

// File: rtl/dcache_memresp.sv
// Memory-port responder: absorbs flush writes, answers line-fill reads with fixed bursts.
// Define DCACHE_MEMRESP_GAP_EN to insert one idle cycle between consecutive read beats.
module dcache_memresp
   import dcache_memresp_pkg::*;
#(
   parameter int ADDRBITS  = DC_ADDRBITS,
   parameter int DATABITS  = DC_DATABITS,
   parameter int BURSTLEN  = 8,
   parameter int RDLATENCY = 2,
   parameter int DEPTHBITS = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDRBITS-1:0] mem_addr,
   input  logic                mem_rdreq,
   input  logic                mem_wrreq,
   input  logic [DATABITS-1:0] mem_datain,
   output logic [DATABITS-1:0] mem_out,
   output logic                mem_valid,
   output logic [15:0]         mem_burstlen,
   output logic                mem_busy,
   output logic                mem_err
);

`ifdef DCACHE_MEMRESP_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   localparam logic [4:0] LAST_BEAT = 5'(BURSTLEN - 1);
   localparam logic [3:0] LAT_INIT  = 4'(RDLATENCY - 1);

   state_t               r_state;
   logic [3:0]           r_lat_cnt;
   logic [4:0]           r_beat_cnt;
   logic [DEPTHBITS-1:0] r_ptr;
   logic                 r_valid;
   logic                 r_err;

   state_t               w_state_nxt;
   logic [3:0]           w_lat_nxt;
   logic [4:0]           w_beat_nxt;
   logic [DEPTHBITS-1:0] w_ptr_nxt;
   logic                 w_valid_nxt;
   logic                 w_err_nxt;
   logic                 w_we;
   logic [DEPTHBITS-1:0] w_index;
   logic [DATABITS-1:0]  w_ram_dout;
   logic                 w_unused_addr;

   assign w_index       = mem_addr[DEPTHBITS+1:2];
   assign w_unused_addr = ^{mem_addr[ADDRBITS-1:DEPTHBITS+2], mem_addr[1:0]};

   dpram_word #(
      .DATABITS  (DATABITS),
      .DEPTHBITS (DEPTHBITS)
   ) u_ram (
      .clk     (clk),
      .we      (w_we),
      .waddr   (w_index),
      .raddr   (r_ptr),
      .datain  (mem_datain),
      .dataout (w_ram_dout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_lat_cnt  <= '0;
         r_beat_cnt <= '0;
         r_ptr      <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lat_cnt  <= w_lat_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_ptr      <= w_ptr_nxt;
         r_valid    <= w_valid_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // The RAM always reads at r_ptr, so a beat is "issued" simply by raising valid and advancing ptr.
   always_comb begin
      w_state_nxt = r_state;
      w_lat_nxt   = r_lat_cnt;
      w_beat_nxt  = r_beat_cnt;
      w_ptr_nxt   = r_ptr;
      w_valid_nxt = 1'b0;
      w_err_nxt   = r_err;
      w_we        = 1'b0;
      case (r_state)
         IDLE: begin
            w_we = mem_wrreq;
            if (mem_rdreq && mem_wrreq) begin
               w_err_nxt = 1'b1;
            end else if (mem_rdreq) begin
               w_ptr_nxt   = w_index;
               w_lat_nxt   = LAT_INIT;
               w_beat_nxt  = '0;
               w_state_nxt = RDLAT;
            end
         end
         RDLAT: begin
            if (mem_rdreq || mem_wrreq) begin
               w_err_nxt = 1'b1;
            end
            if (r_lat_cnt == '0) begin
               w_state_nxt = RDBURST;
               w_valid_nxt = 1'b1;
               w_ptr_nxt   = r_ptr + 1'b1;
            end else begin
               w_lat_nxt = r_lat_cnt - 1'b1;
            end
         end
         RDBURST: begin
            if (mem_rdreq || mem_wrreq) begin
               w_err_nxt = 1'b1;
            end
            // A low r_valid inside RDBURST can only be a gap cycle.
            if (r_valid && (r_beat_cnt == LAST_BEAT)) begin
               w_state_nxt = IDLE;
            end else if (GAP_EN && r_valid) begin
               w_valid_nxt = 1'b0;
            end else begin
               w_valid_nxt = 1'b1;
               w_ptr_nxt   = r_ptr + 1'b1;
               w_beat_nxt  = r_beat_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign mem_out      = r_valid ? w_ram_dout : '0;
   assign mem_valid    = r_valid;
   assign mem_busy     = (r_state != IDLE);
   assign mem_err      = r_err;
   assign mem_burstlen = 16'(BURSTLEN);

endmodule

// File: tb/tb_dcache_memresp.sv
// Bench for dcache_memresp: cycle-indexed expectation model plus literal checks.
module tb_dcache_memresp;

   localparam int DEPTH = 1024;
   localparam int BL    = 8;
   localparam int RDL   = 2;
`ifdef DCACHE_MEMRESP_GAP_EN
   localparam int BEAT_STEP = 2;
`else
   localparam int BEAT_STEP = 1;
`endif

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [31:0] mem_addr   = '0;
   logic        mem_rdreq  = 1'b0;
   logic        mem_wrreq  = 1'b0;
   logic [31:0] mem_datain = '0;
   logic [31:0] mem_out;
   logic        mem_valid;
   logic [15:0] mem_burstlen;
   logic        mem_busy;
   logic        mem_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;
   int err_at  = -1;

   logic [31:0] mem_model [DEPTH];
   bit          exp_valid [int];
   logic [31:0] exp_data  [int];
   bit          exp_busy  [int];
   logic [31:0] cap_data [$];
   int          cap_cyc  [$];

   dcache_memresp #(
      .ADDRBITS  (32),
      .DATABITS  (32),
      .BURSTLEN  (BL),
      .RDLATENCY (RDL),
      .DEPTHBITS (10)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_addr     (mem_addr),
      .mem_rdreq    (mem_rdreq),
      .mem_wrreq    (mem_wrreq),
      .mem_datain   (mem_datain),
      .mem_out      (mem_out),
      .mem_valid    (mem_valid),
      .mem_burstlen (mem_burstlen),
      .mem_busy     (mem_busy),
      .mem_err      (mem_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model; cycle m means "after posedge number m".
   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", {31'b0, mem_valid}, exp_valid.exists(cyc) ? 32'd1 : 32'd0);
         check("busy",  {31'b0, mem_busy},  exp_busy.exists(cyc)  ? 32'd1 : 32'd0);
         check("err",   {31'b0, mem_err},   (err_at >= 0 && cyc >= err_at) ? 32'd1 : 32'd0);
         if (exp_valid.exists(cyc)) begin
            check("beat data", mem_out, exp_data[cyc]);
         end
      end
      if (mem_valid === 1'b1) begin
         cap_data.push_back(mem_out);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic set_err(input int t);
      if (err_at < 0) err_at = t;
   endtask

   // Apply inputs now (at a negedge) and predict the effect of the next posedge.
   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      int t;
      int idx;
      t   = cyc + 1;
      idx = int'((addr >> 2) % DEPTH);
      mem_rdreq  = rd;
      mem_wrreq  = wr;
      mem_addr   = addr;
      mem_datain = data;
      if (!exp_busy.exists(cyc)) begin
         if (wr) mem_model[idx] = data;
         if (rd && wr) begin
            set_err(t);
         end else if (rd) begin
            for (int k = 0; k < BL; k++) begin
               exp_valid[t + RDL + k * BEAT_STEP] = 1'b1;
               exp_data[t + RDL + k * BEAT_STEP]  = mem_model[(idx + k) % DEPTH];
            end
            for (int c = t; c <= t + RDL + (BL - 1) * BEAT_STEP; c++) exp_busy[c] = 1'b1;
         end
      end else if (rd || wr) begin
         set_err(t);
      end
   endtask

   task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      drive(rd, wr, addr, data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic rd_first_idle(input logic [31:0] addr, output int t_req);
      int g;
      g = 0;
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      while (exp_busy.exists(cyc) && g < 200) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 32'h0, 32'h0);
         g++;
      end
      if (g >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle wait: busy never cleared within 200 cycles");
      end
      t_req = cyc + 1;
      drive(1'b1, 1'b0, addr, 32'h0);
   endtask

   task automatic cap_clear();
      cap_data.delete();
      cap_cyc.delete();
   endtask

   initial begin
      int t;
      int g;
      int tb3;
      repeat (2) @(negedge clk);
      check("reset valid",    {31'b0, mem_valid}, 32'd0);
      check("reset busy",     {31'b0, mem_busy},  32'd0);
      check("reset err",      {31'b0, mem_err},   32'd0);
      check("reset out",      mem_out,            32'd0);
      check("burstlen",       {16'b0, mem_burstlen}, 32'd8);
      #1 reset_n = 1'b1;
      chk_en = 1'b1;

      for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 32'h100 + 4 * i, 32'hA000_0000 + i);
      idle(2);

      cap_clear();
      rd_first_idle(32'h100, t);
      idle(14);
      check("burst1 count", 32'(cap_data.size()), 32'd8);
      check("burst1 first cycle", 32'(cap_cyc[0]), 32'(t + 2));
      for (int k = 0; k < 8; k++) check("burst1 data", cap_data[k], 32'hA000_0000 + k);

      cap_clear();
      for (int b = 0; b < 4; b++) rd_first_idle(32'h100 + 32 * b, t);
      idle(14);
      check("fill count", 32'(cap_data.size()), 32'd32);
      for (int k = 0; k < 32; k++) check("fill data", cap_data[k], 32'hA000_0000 + k);
      check("fill turnaround", 32'(cap_cyc[8] - cap_cyc[7]), 32'd4);

      cap_clear();
      rd_first_idle(32'h100, t);
      idle(2);
      step(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF);
      idle(12);
      check("err sticky", {31'b0, mem_err}, 32'd1);
      check("errburst count", 32'(cap_data.size()), 32'd8);
      for (int k = 0; k < 8; k++) check("errburst data", cap_data[k], 32'hA000_0000 + k);
      cap_clear();
      rd_first_idle(32'h100, t);
      idle(14);
      check("ram 0x104 kept", cap_data[1], 32'hA000_0001);

      step(1'b0, 1'b1, 32'hFF8, 32'hB000_03FE);
      step(1'b0, 1'b1, 32'hFFC, 32'hB000_03FF);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h0 + 4 * i, 32'hB000_0000 + i);
      idle(1);
      cap_clear();
      rd_first_idle(32'hFF8, t);
      idle(14);
      check("wrap count", 32'(cap_data.size()), 32'd8);
      check("wrap beat0", cap_data[0], 32'hB000_03FE);
      check("wrap beat1", cap_data[1], 32'hB000_03FF);
      check("wrap beat2", cap_data[2], 32'hB000_0000);
      check("wrap beat7", cap_data[7], 32'hB000_0005);

      cap_clear();
      rd_first_idle(32'h100, t);
      tb3 = t + RDL + 3 * BEAT_STEP;
      g = 0;
      while (cyc < tb3 && g < 50) begin
         step(1'b0, 1'b0, 32'h0, 32'h0);
         g++;
      end
      check("pre-reset valid", {31'b0, mem_valid}, 32'd1);
      check("pre-reset beat3", mem_out, 32'hA000_0003);
      #2 reset_n = 1'b0;
      exp_valid.delete();
      exp_data.delete();
      exp_busy.delete();
      err_at = -1;
      #1;
      check("midreset valid", {31'b0, mem_valid}, 32'd0);
      check("midreset busy",  {31'b0, mem_busy},  32'd0);
      check("midreset err",   {31'b0, mem_err},   32'd0);
      check("midreset out",   mem_out,            32'd0);
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;
      cap_clear();
      rd_first_idle(32'h100, t);
      idle(14);
      check("post-reset count", 32'(cap_data.size()), 32'd8);
      for (int k = 0; k < 8; k++) check("post-reset data", cap_data[k], 32'hA000_0000 + k);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dcache_memresp.md
Name: dcache_memresp

Overview:
- Memory-side responder for the dcache line's memory port: accepts line fill reads and flush writes, serves them from an internal word-addressed RAM.
- Advertises a fixed burst length.
- Returns exactly that many read beats per read request; absorbs one write word per cycle.
- Used as the memory controller endpoint for dcache simulation and FPGA bring-up.

Parameters:
- ADDRBITS, 32, byte address width of mem_addr.
- DATABITS, 32, data word width.
- BURSTLEN, 8, words returned per read request; 1..32, must divide 32 (cache line words).
- RDLATENCY, 2, cycles from sampling mem_rdreq to first mem_valid beat; 1..15.
- DEPTHBITS, 10, log2 of RAM depth in words.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- mem_addr  in  ADDRBITS  byte address from cache; bits [1:0] ignored
- mem_rdreq  in  1  single-cycle read burst request
- mem_wrreq  in  1  write strobe, one word per cycle while high
- mem_datain  in  DATABITS  write data, valid with mem_wrreq
- mem_out  out  DATABITS  read data, valid when mem_valid=1
- mem_valid  out  1  read beat strobe
- mem_burstlen  out  16  constant BURSTLEN, zero-extended
- mem_busy  out  1  high while a read burst is pending or active
- mem_err  out  1  sticky protocol error flag

Behaviour:
- Reset: clock and reset as already decided — one clock, clk; reset_n is asynchronous and active-low. State is IDLE. mem_out=0, mem_valid=0, mem_busy=0, mem_err=0. RAM contents are not reset. mem_burstlen is combinational and equals BURSTLEN even during reset.
- Word index: mem_addr[DEPTHBITS+1:2]. Upper bits are ignored, so addresses alias modulo 2^DEPTHBITS words.
- State IDLE:
  - mem_wrreq=1: write mem_datain to RAM[index] at this edge. Stay in IDLE. Back-to-back writes are accepted every cycle, no stall.
  - mem_rdreq=1 with mem_wrreq=0: latch the index into the burst pointer, load lat_cnt=RDLATENCY-1, beat_cnt=0. Go to RDLAT; mem_busy goes to 1.
  - mem_rdreq=1 and mem_wrreq=1 together: the write executes, the read is dropped, mem_err is set.
- State RDLAT:
  - Decrement lat_cnt each cycle.
  - At 0, issue the RAM read at the burst pointer and go to RDBURST.
- State RDBURST:
  - One beat per cycle: mem_valid=1, mem_out=RAM[ptr]. Increment ptr and beat_cnt.
  - ptr wraps modulo 2^DEPTHBITS.
- Beat timing: read request sampled at edge T → first mem_valid high in the cycle after edge T+RDLATENCY. Beats are contiguous; the last is beat BURSTLEN-1.
- Burst end: after the last beat, mem_valid=0 and mem_busy=0 on the following edge, and the state returns to IDLE. A new mem_rdreq is accepted in that same IDLE cycle.
- Errors (RDLAT/RDBURST): mem_wrreq or mem_rdreq seen in either state sets mem_err and is otherwise ignored. The burst continues undisturbed, and no RAM write occurs.
- mem_err clears only on reset.
- Read-after-write: a write at edge T is visible to a read whose RAM read is issued at an edge after T. The RAM is read-first on same-address collision, which cannot occur legally.
- Reset mid-burst: the burst is abandoned, mem_valid drops asynchronously and no further beats follow.

Optional Feature:
- DCACHE_MEMRESP_GAP_EN defined: one idle cycle (mem_valid=0) is inserted after every beat except the last. A burst then takes 2*BURSTLEN-1 cycles; mem_busy stays high across the gaps. This exercises the cache's tolerance of non-contiguous mem_valid.
- Undefined: beats are contiguous as above.

Decomposition:
- Shared header holds:
  - ADDRBITS, DATABITS and CACHEWORDS defines, common with the dcache;
  - state encodings IDLE=2'b00, RDLAT=2'b01, RDBURST=2'b10.
- One sub-module, dpram_word: a synchronous 1R1W word RAM with raddr, waddr, datain, we, dataout and clk, widths set from DATABITS/DEPTHBITS. It is a word-wide counterpart of the byte-wide dcache RAM.
- The state machine, counters and error logic stay in dcache_memresp.

Test Plan:
- Write 32 consecutive cycles with mem_addr=0x100+4*i and data=0xA000_0000+i → all accepted, mem_busy stays 0, mem_err=0.
- Then mem_rdreq with addr 0x100, RDLATENCY=2, BURSTLEN=8 → first mem_valid in the cycle after edge T+2. Require 8 contiguous beats 0xA000_0000..0xA000_0007, then mem_valid=0 and mem_busy=0.
- Four back-to-back bursts at 0x100, 0x120, 0x140, 0x160, each issued in the first IDLE cycle → 32 beats total, matching the written data. Models a dcache line fill.
- mem_wrreq pulse during RDBURST at addr 0x104 → mem_err=1, burst data unchanged, RAM[0x104] unchanged on readback.
- Read at word index 2^DEPTHBITS-2 (addr 0xFF8 with DEPTHBITS=10) → beats come from indices 1022, 1023, 0, 1, ..., showing wrap.
- reset_n low during beat 3 → mem_valid, mem_busy and mem_err drop immediately. After release, a new read returns the full 8 beats.
